// File: rtl/nn_pkg.sv
// Shared neural-net package.
//  FRAC_DEF   default fractional bit count (Q16.16 datapath)
//  ONE_FX     1.0 in the default Q16.16 format
//  state_t    sequential neuron FSM states
//  clog2      elaboration-time ceil(log2) helper
//  tanh_q16   tanh breakpoints at k*0.25 (k = 0..16) in Q1.16, rounded to nearest
package nn_pkg;

  localparam int          FRAC_DEF = 16;
  localparam logic [31:0] ONE_FX   = 32'h0001_0000;

  typedef enum logic [1:0] {IDLE, MAC, ACT, HOLD} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Beyond the last breakpoint the curve is treated as exactly 1.0.
  function automatic logic [16:0] tanh_q16(input logic [4:0] k);
    case (k)
      5'd0:    return 17'd0;
      5'd1:    return 17'd16051;
      5'd2:    return 17'd30285;
      5'd3:    return 17'd41625;
      5'd4:    return 17'd49912;
      5'd5:    return 17'd55593;
      5'd6:    return 17'd59320;
      5'd7:    return 17'd61694;
      5'd8:    return 17'd63178;
      5'd9:    return 17'd64096;
      5'd10:   return 17'd64659;
      5'd11:   return 17'd65000;
      5'd12:   return 17'd65212;
      5'd13:   return 17'd65339;
      5'd14:   return 17'd65417;
      5'd15:   return 17'd65464;
      5'd16:   return 17'd65492;
      default: return 17'd65536;
    endcase
  endfunction

endpackage

// File: rtl/neuron_mac_seq_tanh.sv
// Combinational fixed-point tanh, piecewise linear over 0.25-wide segments
// on [0,4), odd-symmetric, |a| >= 4.0 returns +/-1.0. Max error ~0.006.
//  a  in   WIDTH  signed Q(WIDTH-FRAC).FRAC argument
//  y  out  WIDTH  signed tanh(a), same format
// Requires FRAC >= 3 and WIDTH > FRAC+2.
module neuron_mac_seq_tanh
  import nn_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  localparam int FW = FRAC - 2;  // fraction bits inside one 0.25 segment
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

  function automatic logic [2*WIDTH-1:0] scale(input logic [16:0] q);
    logic [2*WIDTH-1:0] v;
    v = {{(2*WIDTH-17){1'b0}}, q};
    if (FRAC >= 16) return v << (FRAC - 16);
    else            return v >> (16 - FRAC);
  endfunction

  logic               neg, big;
  logic [WIDTH-1:0]   mag, mag_y;
  logic [3:0]         seg;
  logic [FW-1:0]      fr;
  logic [2*WIDTH-1:0] y0, y1, step;

  always_comb begin
    neg   = a[WIDTH-1];
    // most-negative input negates to itself; as unsigned it lands in 'big'
    mag   = neg ? -a : a;
    big   = |mag[WIDTH-1:FRAC+2];
    seg   = mag[FRAC+1:FW];
    fr    = mag[FW-1:0];
    y0    = scale(tanh_q16({1'b0, seg}));
    y1    = scale(tanh_q16({1'b0, seg} + 5'd1));
    step  = ((y1 - y0) * {{(2*WIDTH-FW){1'b0}}, fr}) >> FW;
    mag_y = big ? ONE : WIDTH'(y0 + step);
    y     = neg ? -mag_y : mag_y;
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential N_IN-input neuron: y = tanh(sum_i a_i*w_i + b), one multiplier
// folded over N_IN cycles, valid/ready on both sides.
//  clk, rst            clock, async active-high reset
//  in_valid/in_ready   input handshake for a_vec, w_vec, b
//  a_vec, w_vec        N_IN packed operands, element i at [i*WIDTH +: WIDTH]
//  b                   bias
//  out_valid/out_ready output handshake for y
//  y                   activated result, held until taken
//  busy                FSM not idle
// Build option: NEURON_MAC_SAT_EN -> saturating accumulator-to-WIDTH
// reduction; otherwise the low WIDTH bits are kept (wrap).
module neuron_mac_seq
  import nn_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = FRAC_DEF,
  parameter int N_IN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*WIDTH-1:0] a_vec,
  input  logic [N_IN*WIDTH-1:0] w_vec,
  input  logic [WIDTH-1:0]      b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      y,
  output logic                  busy
);

  localparam int ACC_W = WIDTH + clog2(N_IN) + 1;
  localparam int IDX_W = (N_IN > 1) ? clog2(N_IN) : 1;

  state_t state, state_nxt;

  logic [N_IN-1:0][WIDTH-1:0] a_q, w_q;
  logic signed [ACC_W-1:0]    acc, term;
  logic [IDX_W-1:0]           idx;
  logic                       last;
  logic signed [WIDTH-1:0]    a_sel, w_sel;
  logic signed [2*WIDTH-1:0]  prod;
  logic [WIDTH-1:0]           pre, act;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = MAC;
      end
      MAC:  if (last) state_nxt = ACT;
      ACT:  state_nxt = HOLD;
      HOLD: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  assign last  = (idx == IDX_W'(N_IN - 1));
  assign a_sel = a_q[idx];
  assign w_sel = w_q[idx];
  assign prod  = (2*WIDTH)'(a_sel) * (2*WIDTH)'(w_sel);
  // floor-rounded product, wrapped into the accumulator (no per-term clamp)
  assign term  = ACC_W'(prod >>> FRAC);

`ifdef NEURON_MAC_SAT_EN
  logic ovf;
  assign ovf = (acc[ACC_W-1:WIDTH-1] != {(ACC_W-WIDTH+1){acc[ACC_W-1]}});
  assign pre = !ovf         ? acc[WIDTH-1:0] :
               acc[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                              {1'b0, {(WIDTH-1){1'b1}}};
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc[ACC_W-1:WIDTH];
  assign pre = acc[WIDTH-1:0];
`endif

  neuron_mac_seq_tanh #(.WIDTH(WIDTH), .FRAC(FRAC)) u_tanh (
    .a (pre),
    .y (act)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      w_q       <= '0;
      acc       <= '0;
      idx       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a_vec;
          w_q <= w_vec;
          acc <= ACC_W'($signed(b));
          idx <= '0;
        end
        MAC: begin
          acc <= acc + term;
          idx <= idx + IDX_W'(1);
        end
        ACT: begin
          y         <= act;
          out_valid <= 1'b1;
        end
        HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq (WIDTH=32, FRAC=16, N_IN=4).
// Expected y values are true tanh results in Q16.16; tolerance is 4 LSB at
// segment breakpoints, 0x100 between them. Honors NEURON_MAC_SAT_EN.
module tb_neuron_mac_seq;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [N*W-1:0] a_vec, w_vec;
  logic [W-1:0]   b, y;
  int             n_cmp = 0;
  int             n_err = 0;
  int             lat;
  logic [W-1:0]   exp4;

  always #5 clk = ~clk;

  neuron_mac_seq #(.WIDTH(W), .FRAC(16), .N_IN(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_vec     (a_vec),
    .w_vec     (w_vec),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
    int d;
    d = int'($signed(obs - exp));
    n_cmp++;
    if (d > tol || d < -tol) begin
      n_err++;
      $display("FAIL %s: got %h want %h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Present one vector, scramble the inputs after accept, wait for out_valid.
  task automatic send(input logic [N*W-1:0] a, input logic [N*W-1:0] w,
                      input logic [W-1:0] bb, output int n);
    @(negedge clk);
    chk("accept_rdy", 32'(in_ready), 32'd1, 0);
    a_vec = a; w_vec = w; b = bb; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a_vec = '1; w_vec = '1; b = '1;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [N*W-1:0] a, input logic [N*W-1:0] w,
                     input logic [W-1:0] bb, input logic [W-1:0] exp, input int tol);
    int n;
    send(a, w, bb, n);
    chk({tag, "_lat"}, 32'(n), 32'd5, 0);
    chk({tag, "_y"}, y, exp, tol);
    @(negedge clk);
    chk({tag, "_idle"}, 32'(in_ready), 32'd1, 0);
    chk({tag, "_ovld0"}, 32'(out_valid), 32'd0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_vec = '0; w_vec = '0; b = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1, 0);
    chk("rst_out_valid", 32'(out_valid), 32'd0, 0);
    chk("rst_y", y, 32'h0, 0);
    chk("rst_busy", 32'(busy), 32'd0, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: all zero
    run("zero", '0, '0, 32'h0, 32'h0000_0000, 0);
    // 2: 4 * (1.0*0.5) = 2.0 -> 0.96403
    run("two", {4{32'h0001_0000}}, {4{32'h0000_8000}}, 32'h0, 32'h0000_F6CA, 4);
    // 3: 1-1+2-2 + (-1.0) = -1.0 -> -0.76159
    run("neg1", {32'hFFFE_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h0001_0000},
        {4{32'h0001_0000}}, 32'hFFFF_0000, 32'hFFFF_3D08, 4);
    // 0.5 -> 0.46212 ; 0.125 -> 0.12435 ; -0.125 via negative weight
    run("half", {96'h0, 32'h0000_8000}, {4{32'h0001_0000}}, 32'h0, 32'h0000_764D, 4);
    run("eighth", {96'h0, 32'h0000_2000}, {4{32'h0001_0000}}, 32'h0, 32'h0000_1FD6, 256);
    run("neighth", {96'h0, 32'h0000_2000}, {4{32'hFFFF_0000}}, 32'h0, 32'hFFFF_E02A, 256);
    // 4: 4 * 100*100 = 40000.0: saturates to max, or wraps to -25536.0
`ifdef NEURON_MAC_SAT_EN
    exp4 = 32'h0001_0000;
`else
    exp4 = 32'hFFFF_0000;
`endif
    run("big", {4{32'h0064_0000}}, {4{32'h0064_0000}}, 32'h0, exp4, 4);

    // 5: downstream stall
    out_ready = 1'b0;
    send({4{32'h0001_0000}}, {4{32'h0000_8000}}, 32'h0, lat);
    chk("stall_lat", 32'(lat), 32'd5, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_y", y, 32'h0000_F6CA, 4);
      chk("stall_ovld", 32'(out_valid), 32'd1, 0);
      chk("stall_irdy", 32'(in_ready), 32'd0, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_irdy", 32'(in_ready), 32'd1, 0);
    chk("release_ovld", 32'(out_valid), 32'd0, 0);
    chk("release_busy", 32'(busy), 32'd0, 0);

    // 6: reset in the second MAC cycle
    @(negedge clk);
    a_vec = {4{32'h0001_0000}}; w_vec = {4{32'h0001_0000}}; b = 32'h0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mac_busy", 32'(busy), 32'd1, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_irdy", 32'(in_ready), 32'd1, 0);
    chk("mid_rst_ovld", 32'(out_valid), 32'd0, 0);
    chk("mid_rst_y", y, 32'h0, 0);
    chk("mid_rst_busy", 32'(busy), 32'd0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_ovld", 32'(out_valid), 32'd0, 0);
    end
    run("after_rst", {4{32'h0001_0000}}, {4{32'h0000_8000}}, 32'h0, 32'h0000_F6CA, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
